fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller_pkg.sv | 21 ++
 rtl/fetch_controller_hold_buffer.sv | 61 ++++++
 rtl/fetch_controller.sv | 219 +++++++++++++++++++++
 tb/tb_fetch_controller.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_controller_pkg.sv
// -----------------------------------------------------------------------------
// fetch_controller_pkg
// Shared definitions for the instruction fetch controller: FSM state encoding,
// instruction word width, sequential PC step and the default start address.
// No ports (package).
// -----------------------------------------------------------------------------
package fetch_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } fetch_state_e;

    localparam int          INST_W           = 32;
    localparam int          PC_STEP          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_controller_hold_buffer.sv
// -----------------------------------------------------------------------------
// inst_hold_buffer
// Single-entry valid/ready register holding one fetched instruction and its PC.
// A load always wins; otherwise the entry empties on flush or on a downstream
// handshake. Data/PC keep their last value once the entry is emptied.
//
// Ports:
//   clk      - clock (rising edge)
//   rst      - asynchronous active-low reset
//   i_load   - capture i_data/i_pc and mark the entry valid
//   i_data   - instruction word to capture
//   i_pc     - address of i_data
//   i_flush  - drop the entry
//   i_ready  - downstream consumes the entry when o_valid is high
//   o_valid  - entry holds an instruction
//   o_data   - buffered instruction word
//   o_pc     - buffered instruction address
// -----------------------------------------------------------------------------
module inst_hold_buffer
    import fetch_controller_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [INST_W-1:0] i_data,
    input  logic [WIDTH-1:0]  i_pc,
    input  logic              i_flush,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [INST_W-1:0] o_data,
    output logic [WIDTH-1:0]  o_pc
);

    logic              r_valid;
    logic [INST_W-1:0] r_data;
    logic [WIDTH-1:0]  r_pc;

    // Entry register: load has priority over flush/consume.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= {INST_W{1'b0}};
            r_pc    <= {WIDTH{1'b0}};
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_pc    <= i_pc;
        end else if (i_flush || (r_valid && i_ready)) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
// Single-outstanding instruction fetch engine. Issues one word-aligned request
// at a time, buffers the returned word in a one-entry hold buffer and hands it
// downstream with valid/ready. Redirects compute the new PC relative to the
// last consumed instruction; responses belonging to a squashed request are
// drained and discarded.
//
// Ports:
//   clk             - clock (rising edge)
//   rst             - asynchronous active-low reset
//   start           - pulse; begins fetching at RESET_PC when idle
//   redirect_valid  - pulse; taken branch/jump
//   redirect_offset - signed byte offset from the last consumed PC
//   imem_req_valid  - memory request valid (registered)
//   imem_req_addr   - memory request address (registered, word aligned)
//   imem_req_ready  - memory accepts the request
//   imem_rsp_valid  - memory response valid (one per accepted request)
//   imem_rsp_data   - memory response word
//   inst_valid      - buffered instruction available
//   inst_ready      - downstream consumes the instruction
//   inst_data       - buffered instruction word
//   inst_pc         - address of inst_data
//   busy            - controller not idle (registered)
// -----------------------------------------------------------------------------
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              redirect_valid,
    input  logic [WIDTH-1:0]  redirect_offset,
    output logic              imem_req_valid,
    output logic [WIDTH-1:0]  imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [WIDTH-1:0]  inst_pc,
    output logic              busy
);

    // Word-aligned redirect target; the sum wraps modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] redirect_target(
        input logic [WIDTH-1:0] base,
        input logic [WIDTH-1:0] offset
    );
        logic [WIDTH-1:0] sum;
        sum = base + offset;
        return {sum[WIDTH-1:2], 2'b00};
    endfunction

    fetch_state_e     r_state;
    fetch_state_e     w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] r_last_pc;
    logic [WIDTH-1:0] w_last_pc_nxt;
    logic             r_kill;
    logic             w_kill_nxt;
    logic             r_req_valid;
    logic [WIDTH-1:0] r_req_addr;
    logic             r_busy;

    logic              w_load;
    logic              w_flush;
    logic              w_handshake;
    logic [WIDTH-1:0]  w_base;
    logic [WIDTH-1:0]  w_target;
    logic              w_buf_valid;
    logic [INST_W-1:0] w_buf_data;
    logic [WIDTH-1:0]  w_buf_pc;

    // A handshake in the same cycle as a redirect completes first, so the
    // instruction being consumed becomes the redirect base.
    assign w_handshake = w_buf_valid & inst_ready;
    assign w_base      = w_handshake ? w_buf_pc : r_last_pc;
    assign w_target    = redirect_target(w_base, redirect_offset);

    // FSM state and PC bookkeeping registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_pc      <= RESET_PC;
            r_last_pc <= RESET_PC;
            r_kill    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_last_pc <= w_last_pc_nxt;
            r_kill    <= w_kill_nxt;
        end
    end

    // Next-state, next-PC and buffer control.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_last_pc_nxt = w_base;
        w_kill_nxt    = r_kill;
        w_load        = 1'b0;
        w_flush       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_REQ;
                    w_pc_nxt    = RESET_PC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (imem_req_ready) begin
                    // A request already squashed (kill) or squashed now must
                    // have its response drained.
                    w_kill_nxt  = 1'b0;
                    w_state_nxt = (r_kill || redirect_valid) ? ST_DRAIN : ST_WAIT;
                    if (redirect_valid) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_pc_nxt = r_pc;
                    end
                end else if (redirect_valid) begin
                    // Request must stay stable; remember to discard its data.
                    w_pc_nxt   = w_target;
                    w_kill_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = imem_rsp_valid ? ST_REQ : ST_DRAIN;
                end else if (imem_rsp_valid) begin
                    w_load      = 1'b1;
                    w_pc_nxt    = r_pc + WIDTH'(PC_STEP);
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    w_flush     = 1'b1;
                    w_pc_nxt    = w_target;
                    w_state_nxt = ST_REQ;
                end else if (w_handshake) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_target;
                end else begin
                    w_pc_nxt = r_pc;
                end
                if (imem_rsp_valid) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_kill_nxt  = 1'b0;
            end
        endcase
    end

    // Registered request/busy outputs; the address is captured only on entry
    // to REQ so it holds steady while a stalled request waits for ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_valid <= 1'b0;
            r_req_addr  <= RESET_PC;
            r_busy      <= 1'b0;
        end else begin
            r_req_valid <= (w_state_nxt == ST_REQ);
            r_busy      <= (w_state_nxt != ST_IDLE);
            if ((w_state_nxt == ST_REQ) && (r_state != ST_REQ)) begin
                r_req_addr <= w_pc_nxt;
            end else begin
                r_req_addr <= r_req_addr;
            end
        end
    end

    inst_hold_buffer #(
        .WIDTH (WIDTH)
    ) u_hold_buffer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_data  (imem_rsp_data),
        .i_pc    (r_pc),
        .i_flush (w_flush),
        .i_ready (inst_ready),
        .o_valid (w_buf_valid),
        .o_data  (w_buf_data),
        .o_pc    (w_buf_pc)
    );

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_req_addr;
    assign inst_valid     = w_buf_valid;
    assign inst_data      = w_buf_data;
    assign inst_pc        = w_buf_pc;
    assign busy           = r_busy;

endmodule

// File: tb/tb_fetch_controller.sv
// -----------------------------------------------------------------------------
// tb_fetch_controller
// Bench for fetch_controller. A zero-wait memory model answers each accepted
// request on the following cycle with mem_word(addr). Expected request
// addresses and delivered instructions are queued when stimulus is set up and
// compared when the DUT accepts a request or hands an instruction downstream.
// Redirect scenarios come from a table; reset/stall/throughput cases are
// written out by hand.
// -----------------------------------------------------------------------------
module tb_fetch_controller;

    localparam int PH_HOLD       = 0;
    localparam int PH_HOLD_HS    = 1;
    localparam int PH_WAIT_RSP   = 2;
    localparam int PH_WAIT_NORSP = 3;
    localparam int PH_REQ_ACC    = 4;
    localparam int PH_REQ_STALL  = 5;

    typedef struct {
        int          n;      // instructions consumed before the redirect
        int          phase;  // where the redirect pulse lands
        logic [31:0] off;    // redirect offset
        logic [31:0] tgt;    // expected redirect target
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        redirect_valid;
    logic [31:0] redirect_offset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        busy;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_inst_q[$];
    int          acc_cycles[$];
    logic        rsp_due = 1'b0;
    logic [31:0] rsp_addr = 32'h0;
    logic        mem_stall = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    vec_t        vecs[7];

    fetch_controller #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .redirect_valid  (redirect_valid),
        .redirect_offset (redirect_offset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive memory response, score outputs, advance to the
    // next falling edge. Called at a falling edge.
    task automatic tick();
        logic        accepted;
        logic        outstanding;
        logic [31:0] e;
        outstanding = rsp_due;
        if (mem_stall || !rsp_due) begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end else begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(rsp_addr);
            rsp_due        = 1'b0;
        end
        #1;
        accepted = imem_req_valid && imem_req_ready;
        if (prev_stall) begin
            check("req_hold_valid", {31'b0, imem_req_valid}, 32'd1);
            check("req_hold_addr", imem_req_addr, prev_addr);
        end
        if (accepted) begin
            check("single_outstanding", {31'b0, outstanding}, 32'd0);
            if (exp_addr_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_req actual=%h expected=none (cycle %0d)", imem_req_addr, cyc);
            end else begin
                e = exp_addr_q.pop_front();
                check("req_addr", imem_req_addr, e);
            end
            acc_cycles.push_back(cyc);
            rsp_due  = 1'b1;
            rsp_addr = imem_req_addr;
        end
        if (inst_valid && inst_ready) begin
            if (exp_inst_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_inst actual=%h expected=none (cycle %0d)", inst_pc, cyc);
            end else begin
                e = exp_inst_q.pop_front();
                check("inst_pc", inst_pc, e);
                check("inst_data", inst_data, mem_word(e));
            end
        end
        prev_stall = imem_req_valid && !imem_req_ready;
        prev_addr  = imem_req_addr;
        @(posedge clk);
        @(negedge clk);
        start          = 1'b0;
        redirect_valid = 1'b0;
        cyc++;
    endtask

    task automatic run_until_empty(input int budget, input string name);
        int k;
        k = 0;
        while ((exp_addr_q.size() != 0 || exp_inst_q.size() != 0) && k < budget) begin
            tick();
            k++;
        end
        n_checks++;
        if (exp_addr_q.size() != 0 || exp_inst_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s timeout actual_pending=%0d/%0d expected=0/0",
                     name, exp_addr_q.size(), exp_inst_q.size());
            exp_addr_q.delete();
            exp_inst_q.delete();
        end
    endtask

    // Assert reset at a falling edge, check outputs immediately, release.
    task automatic do_reset(input logic keep_rsp);
        rst             = 1'b0;
        start           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_offset = 32'h0;
        imem_req_ready  = 1'b1;
        inst_ready      = 1'b1;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = 32'h0;
        #1;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst_data", inst_data, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_addr_q.delete();
        exp_inst_q.delete();
        acc_cycles.delete();
        prev_stall = 1'b0;
        mem_stall  = 1'b0;
        if (!keep_rsp) rsp_due = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] p;
        do_reset(1'b0);
        start = 1'b1;
        tick();
        for (int k = 0; k < v.n; k++) begin
            exp_addr_q.push_back(32'(4 * k));
            exp_inst_q.push_back(32'(4 * k));
        end
        run_until_empty(40, $sformatf("v%0d_consume", idx));
        p = 32'(4 * v.n);
        exp_addr_q.push_back(p);
        imem_req_ready = 1'b1;
        case (v.phase)
            PH_HOLD, PH_HOLD_HS: begin
                inst_ready = 1'b0;
                tick();
                tick();
                if (v.phase == PH_HOLD_HS) begin
                    inst_ready = 1'b1;
                    exp_inst_q.push_back(p);
                end
                redirect_valid  = 1'b1;
                redirect_offset = v.off;
                tick();
            end
            PH_WAIT_RSP: begin
                tick();
                redirect_valid  = 1'b1;
                redirect_offset = v.off;
                tick();
            end
            PH_WAIT_NORSP: begin
                tick();
                mem_stall       = 1'b1;
                redirect_valid  = 1'b1;
                redirect_offset = v.off;
                tick();
                mem_stall = 1'b0;
                tick();
            end
            PH_REQ_ACC: begin
                redirect_valid  = 1'b1;
                redirect_offset = v.off;
                tick();
                tick();
            end
            default: begin
                imem_req_ready  = 1'b0;
                redirect_valid  = 1'b1;
                redirect_offset = v.off;
                tick();
                imem_req_ready = 1'b1;
                tick();
                tick();
            end
        endcase
        inst_ready = 1'b1;
        exp_addr_q.push_back(v.tgt);
        exp_addr_q.push_back(v.tgt + 32'd4);
        exp_inst_q.push_back(v.tgt);
        exp_inst_q.push_back(v.tgt + 32'd4);
        run_until_empty(40, $sformatf("v%0d_post_redirect", idx));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Targets are relative to the last consumed PC (4*(n-1)), or to the
        // instruction consumed in the same cycle for PH_HOLD_HS.
        vecs[0] = '{1, PH_HOLD,       32'h0000_0100, 32'h0000_0100};
        vecs[1] = '{2, PH_HOLD_HS,    32'h0000_0013, 32'h0000_0018};
        vecs[2] = '{5, PH_WAIT_RSP,   32'h0000_0020, 32'h0000_0030};
        vecs[3] = '{2, PH_WAIT_NORSP, 32'hFFFF_FFF0, 32'hFFFF_FFF4};
        vecs[4] = '{1, PH_REQ_ACC,    32'h7FFF_FFFE, 32'h7FFF_FFFC};
        vecs[5] = '{3, PH_REQ_STALL,  32'hFFFF_FFF8, 32'h0000_0000};
        vecs[6] = '{1, PH_HOLD,       32'hFFFF_FFFC, 32'hFFFF_FFFC};

        // Reset state, redirect ignored while idle, then sequential throughput.
        do_reset(1'b0);
        redirect_valid  = 1'b1;
        redirect_offset = 32'h0000_0040;
        tick();
        check("idle_redirect_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("idle_redirect_busy", {31'b0, busy}, 32'd0);
        start = 1'b1;
        tick();
        check("start_busy", {31'b0, busy}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            exp_addr_q.push_back(32'(4 * k));
            exp_inst_q.push_back(32'(4 * k));
        end
        run_until_empty(30, "throughput");
        if (acc_cycles.size() == 3) begin
            check("throughput_gap1", 32'(acc_cycles[1] - acc_cycles[0]), 32'd3);
            check("throughput_gap2", 32'(acc_cycles[2] - acc_cycles[1]), 32'd3);
        end else begin
            check("throughput_accepts", 32'(acc_cycles.size()), 32'd3);
        end

        // Downstream stall in HOLD: buffer stable, no new request, start ignored.
        do_reset(1'b0);
        start = 1'b1;
        tick();
        exp_addr_q.push_back(32'h0);
        exp_inst_q.push_back(32'h0);
        inst_ready = 1'b0;
        for (int k = 0; k < 10 && !inst_valid; k++) tick();
        for (int k = 0; k < 5; k++) begin
            check("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
            check("stall_inst_pc", inst_pc, 32'h0);
            check("stall_inst_data", inst_data, mem_word(32'h0));
            check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
            if (k == 2) start = 1'b1;
            tick();
        end
        inst_ready = 1'b1;
        run_until_empty(10, "stall_release");

        // Redirect table.
        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset during WAIT; the stale response arrives while idle.
        do_reset(1'b0);
        start = 1'b1;
        tick();
        exp_addr_q.push_back(32'h0);
        tick();
        mem_stall = 1'b1;
        tick();
        do_reset(1'b1);
        check("stale_pending", {31'b0, rsp_due}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("stale_inst_valid", {31'b0, inst_valid}, 32'd0);
            check("stale_req_valid", {31'b0, imem_req_valid}, 32'd0);
            check("stale_busy", {31'b0, busy}, 32'd0);
        end
        start = 1'b1;
        tick();
        exp_addr_q.push_back(32'h0);
        exp_inst_q.push_back(32'h0);
        run_until_empty(10, "restart_after_reset");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
